// File: rtl/sisc_pkg.sv
// sisc_pkg: shared state type and default widths for the SISC datapath
package sisc_pkg;
  localparam int SISC_ADDR_W = 16;
  localparam int SISC_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;
endpackage

// File: rtl/lsu_if.sv
// lsu_if: req/ack data-memory bus between the load/store unit and memory
interface lsu_if
  import sisc_pkg::*;
#(
  parameter int ADDR_W = SISC_ADDR_W,
  parameter int DATA_W = SISC_DATA_W
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_timer.sv
// lsu_timer: 8-bit saturating wait counter, expired on the last allowed request cycle
module lsu_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_f,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) r_cnt <= '0;
    else r_cnt <= i_clr ? 8'd0 : (i_en && r_cnt != 8'hFF) ? r_cnt + 8'd1 : r_cnt;
  assign o_expired = r_cnt == 8'(TIMEOUT - 1);
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit turning one ctrl request into a req/ack memory access
module lsu
  import sisc_pkg::*;
#(
  parameter int ADDR_W  = SISC_ADDR_W,
  parameter int DATA_W  = SISC_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  lsu_if.master             mem
);
  lsu_state_t        r_state;
  logic              r_busy, r_done, r_err, r_req, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              w_clr, w_en, w_expired;
  assign w_clr = r_state == IDLE;
  assign w_en  = r_state == REQ && !mem.mem_ack;
  lsu_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_f     (rst_f),
    .i_clr     (w_clr),
    .i_en      (w_en),
    .o_expired (w_expired)
  );
  // An ack in the final timeout cycle takes priority over expiry
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else
      case (r_state)
        IDLE:
          if (start) begin
            r_state <= REQ;
            r_busy  <= 1'b1;
            r_req   <= 1'b1;
            r_we    <= is_store;
            r_addr  <= addr;
            r_wdata <= wdata;
          end
        REQ:
          if (mem.mem_ack || w_expired) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= !mem.mem_ack;
            if (mem.mem_ack && !r_we) r_rdata <= mem.mem_rdata;
          end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign rdata         = r_rdata;
  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the SISC datapath: sits directly downstream of the ALU and upstream of the write-back mux, turning a memory-access request from `ctrl` into a req/ack transaction on the data memory. For loads it captures the returned word for the write-back mux's memory input; for stores it writes `rsb` to memory. It raises `busy` so `ctrl` can hold `pc_write`/`ir_load` until the access completes, and flags accesses the memory never acknowledges.

## Interface
Parameters:
- `ADDR_W`, 16, data-memory word-address width; taken from `alu_result[ADDR_W-1:0]`.
- `DATA_W`, 32, data word width.
- `TIMEOUT`, 15, max cycles `mem_req` is held without `mem_ack` before aborting; legal range 1..255.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst_f`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request from `ctrl`; sampled only in IDLE.
- `is_store`  in  1  1 = store, 0 = load; sampled with `start`.
- `addr`  in  ADDR_W  effective address from the ALU; sampled with `start`.
- `wdata`  in  DATA_W  store data (`rsb`); sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse coincident with `done` when the access timed out.
- `rdata`  out  DATA_W  last loaded word, held until the next successful load.
- `mem_req`  out  1  memory request, held until `mem_ack` or timeout.
- `mem_we`  out  1  write enable, valid while `mem_req`.
- `mem_addr`  out  ADDR_W  memory address, valid while `mem_req`.
- `mem_wdata`  out  DATA_W  memory write data, valid while `mem_req`.
- `mem_ack`  in  1  memory acknowledge; store committed / load data valid in the same cycle.
- `mem_rdata`  in  DATA_W  load data, sampled when `mem_ack` is high.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: `start`=1 → latch `is_store`, `addr`, `wdata` into request registers, clear timeout counter, go to REQ. `start`=0 → stay.
- REQ: `mem_req`=1, `mem_we`/`mem_addr`/`mem_wdata` driven from the request registers, stable for the whole state.
  - `mem_ack`=1 → if load, `rdata` ← `mem_rdata`; go to DONE, err flag clear.
  - `mem_ack`=0 and counter = TIMEOUT-1 → go to DONE, err flag set; `rdata` unchanged.
  - otherwise counter increments (8-bit, saturating; never wraps).
- DONE: `done`=1, `err`=err flag; unconditionally return to IDLE.
- `start` in REQ or DONE is ignored (no queueing). `mem_ack` in IDLE or DONE is ignored.
- Stores never modify `rdata`. Timed-out loads never modify `rdata`.
- `addr` bits above ADDR_W are the caller's concern; no alignment or range checks.

## Timing
- Reset (async, `rst_f`=0): state IDLE; `busy`, `done`, `err`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `rdata` = 0; counter 0. Reset mid-transaction abandons it immediately (`mem_req` drops asynchronously), no `done`.
- All outputs registered or decoded from state only; no combinational path from `start` or `mem_ack` to any output.
- `start` in cycle N → `mem_req`, `busy` high in N+1.
- `mem_ack` in cycle M (M ≥ N+1) → `done`, new `rdata` visible in M+1; `mem_req` low in M+1. Minimum latency start→done = 2 cycles.
- Timeout: with no ack, `mem_req` high for exactly TIMEOUT cycles (N+1 .. N+TIMEOUT); `done`+`err` in N+TIMEOUT+1.
- `mem_ack` in the final timeout cycle wins: normal completion, `err`=0.
- `busy` low in the cycle after DONE; a new `start` is accepted in that cycle, giving back-to-back accesses every 3 cycles at zero memory latency.

## Structure
- Shared package `sisc_pkg`: state enum `lsu_state_t` {IDLE, REQ, DONE}, default widths `SISC_ADDR_W`=16, `SISC_DATA_W`=32.
- One sub-module `lsu_timer`: 8-bit saturating counter with clear/enable and `expired` = (count == TIMEOUT-1).
- `lsu` holds the FSM, request registers and `rdata` register.

## Test plan
- Reset: drive `rst_f`=0 mid-REQ with `mem_req`=1 → `mem_req`, `busy`, `done` = 0 at once; after release, state IDLE, `rdata`=0.
- Zero-wait load: `start`, `is_store`=0, `addr`=16'h0010; memory acks first REQ cycle with 32'hDEADBEEF → `done` 2 cycles after `start`, `rdata`=32'hDEADBEEF, `err`=0.
- Store with 3-cycle wait: `is_store`=1, `addr`=16'h0020, `wdata`=32'h12345678, ack on 3rd REQ cycle → `mem_we`=1 and address/data stable for 3 cycles, memory word updated, `rdata` unchanged.
- Timeout (TIMEOUT=4): no ack → `mem_req` high exactly 4 cycles, then `done`=`err`=1 for 1 cycle, `rdata` unchanged; ack in 4th cycle instead → `err`=0.
- Ignored events: `start` pulsed during REQ and DONE, `mem_ack` pulsed in IDLE → exactly one transaction, one `done`.
- Back-to-back: `start` re-asserted the cycle `busy` falls, zero-wait acks → second `mem_req` rises 1 cycle later, two `done` pulses 3 cycles apart.
